ir_code_uart_framer: RTL and testbench

Downstream consumer of the IR decoder's `code`/`new_code`/`repeat_press` outputs.
- Queues decoded events in a small FIFO and serialises each one into a byte frame.
- Drives a byte-wide UART transmitter through a send/ready handshake.
- Replaces ad-hoc byte-counter logic on test boards, and never loses a frame while the UART is busy, provided the FIFO has not overflowed.

---
 rtl/ir_code_uart_framer.sv | 226 ++++++++++++++++++++++
 tb/tb_ir_code_uart_framer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_code_uart_framer.sv
// ir_code_uart_framer: queues decoded IR events (new code / repeat press) in a
// small FIFO and serialises each one as a byte frame into a send/ready UART.
// Optional build macro: IRFRAME_CHECKSUM_EN appends an XOR checksum byte
// (over the four code bytes only) to every new-code frame.

module ir_code_uart_framer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  HDR_NEW    = 8'hA5,
    parameter logic [7:0]  HDR_RPT    = 8'h5A
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 code_i,
    input  logic                        new_code_i,
    input  logic                        repeat_press_i,
    input  logic                        tx_ready_i,
    output logic [7:0]                  tx_data_o,
    output logic                        tx_send_o,
    output logic [$clog2(FIFO_DEPTH):0] pending_o,
    output logic                        overflow_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 33;

`ifdef IRFRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_NEW = 3'd5;
`else
    localparam logic [2:0] LAST_NEW = 3'd4;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Event capture and FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          rpt_q;

    logic          rpt_edge_c;
    logic          push_c;
    logic          full_c;
    logic          push_ok_c;
    logic          pop_c;
    logic [EW-1:0] push_data_c;
    logic [EW-1:0] head_c;

    // A new code wins over a same-cycle repeat edge; the edge is simply lost.
    always_comb begin
        rpt_edge_c  = repeat_press_i & ~rpt_q;
        push_c      = new_code_i | rpt_edge_c;
        push_data_c = new_code_i ? {1'b0, code_i} : {1'b1, 32'h0};
        full_c      = (count_q == PW'(FIFO_DEPTH));
        push_ok_c   = push_c & ~full_c;
        head_c      = fifo_q[rd_ptr_q];
    end

    // Pointer, occupancy and sticky overflow next-state; push sees pre-pop occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_c && full_c) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + PW'(push_ok_c) - PW'(pop_c);
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_q[wr_ptr_q] <= push_data_c;
        end
    end

    // FIFO control registers and repeat-edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rpt_q      <= repeat_press_i;
        end
    end

    // ------------------------------------------------------------------
    // Frame serialiser
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic        rpt_flag_q, rpt_flag_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_send_q, tx_send_d;
    logic [2:0]  last_idx_c;

`ifdef IRFRAME_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_comb begin
        last_idx_c = rpt_flag_q ? 3'd0 : LAST_NEW;
    end

    // Next-state and output logic: pop in IDLE, hold a byte in SEND, pace in WAIT.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        rpt_flag_d = rpt_flag_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = tx_send_q;
        pop_c      = 1'b0;
`ifdef IRFRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_send_d = 1'b0;
                if (count_q != '0) begin
                    pop_c      = 1'b1;
                    rpt_flag_d = head_c[32];
                    shreg_d    = head_c[31:0];
                    idx_d      = 3'd0;
                    tx_data_d  = head_c[32] ? HDR_RPT : HDR_NEW;
                    tx_send_d  = 1'b1;
                    state_d    = S_SEND;
`ifdef IRFRAME_CHECKSUM_EN
                    csum_d     = head_c[31:24] ^ head_c[23:16] ^
                                 head_c[15:8]  ^ head_c[7:0];
`endif
                end
            end
            S_SEND: begin
                tx_send_d = 1'b1;
                if (!tx_ready_i) begin
                    tx_send_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                tx_send_d = 1'b0;
                if (tx_ready_i) begin
                    if (idx_q == last_idx_c) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        shreg_d   = {shreg_q[23:0], 8'h00};
                        tx_send_d = 1'b1;
                        state_d   = S_SEND;
`ifdef IRFRAME_CHECKSUM_EN
                        tx_data_d = (idx_q == 3'd4) ? csum_q : shreg_q[31:24];
`else
                        tx_data_d = shreg_q[31:24];
`endif
                    end
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Serialiser state register; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            rpt_flag_q <= 1'b0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_send_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rpt_flag_q <= rpt_flag_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
        end
    end

`ifdef IRFRAME_CHECKSUM_EN
    // Checksum of the frame in flight, captured at pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Output mapping.
    always_comb begin
        tx_data_o  = tx_data_q;
        tx_send_o  = tx_send_q;
        pending_o  = count_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_ir_code_uart_framer.sv
// Bench for ir_code_uart_framer: UART model collects transmitted bytes into a
// receive queue; each scenario pushes the bytes it expects and compares them.

module tb_ir_code_uart_framer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   code;
    logic          new_code;
    logic          repeat_press;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic [PW-1:0] pending;
    logic          overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    bit uart_en  = 1'b0;
    bit rand_lat = 1'b0;
    int fix_lat  = 1;
    int lat_cnt  = 0;

    ir_code_uart_framer #(
        .FIFO_DEPTH(DEPTH),
        .HDR_NEW   (8'hA5),
        .HDR_RPT   (8'h5A)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .code_i        (code),
        .new_code_i    (new_code),
        .repeat_press_i(repeat_press),
        .tx_ready_i    (tx_ready),
        .tx_data_o     (tx_data),
        .tx_send_o     (tx_send),
        .pending_o     (pending),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    // UART model: accepts a byte when asked, then stays busy for a latency.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_ready = 1'b1;
                lat_cnt  = 0;
            end else if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) tx_ready = 1'b1;
            end else if (uart_en && tx_send && tx_ready) begin
                rx_q.push_back(tx_data);
                tx_ready = 1'b0;
                lat_cnt  = rand_lat ? int'($urandom_range(1, 20)) : fix_lat;
            end
        end
    end

    // Expected frame for one event.
    task automatic push_exp(input logic [31:0] c, input bit rpt);
        if (rpt) begin
            exp_q.push_back(8'h5A);
        end else begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(c[31:24]);
            exp_q.push_back(c[23:16]);
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
`ifdef IRFRAME_CHECKSUM_EN
            exp_q.push_back(c[31:24] ^ c[23:16] ^ c[15:8] ^ c[7:0]);
`endif
        end
    endtask

    task automatic wait_rx(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rx_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_vec++;
        if (tx_send !== 1'b0 || tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_tx: send=%b data=%h, want 0/00", tx_send, tx_data);
        end
        n_vec++;
        if (pending !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fifo: pending=%0d ovf=%b, want 0/0", pending, overflow);
        end
    endtask

    task automatic test_single_code();
        bit ok;
        logic [7:0] e, a;
        uart_en = 1'b1;
        fix_lat = 1;
        @(negedge clk);
        code = 32'h20DF10EF;
        new_code = 1'b1;
        push_exp(32'h20DF10EF, 1'b0);
        @(posedge clk); #1;
        new_code = 1'b0;
        n_vec++;
        if (pending !== PW'(1) || tx_send !== 1'b0) begin
            n_err++;
            $display("FAIL single_lat_n: pending=%0d send=%b, want 1/0", pending, tx_send);
        end
        @(posedge clk); #1;
        n_vec++;
        if (tx_send !== 1'b1 || tx_data !== 8'hA5 || pending !== '0) begin
            n_err++;
            $display("FAIL single_lat_n1: send=%b data=%h pending=%0d, want 1/a5/0",
                     tx_send, tx_data, pending);
        end
        wait_rx(exp_q.size(), 500, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_timeout: got %0d bytes, want %0d", rx_q.size(), exp_q.size());
        end
        repeat (20) @(negedge clk);
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL single_byte: got %h want %h", a, e);
            end
        end
        n_vec++;
        if (rx_q.size() != 0 || exp_q.size() != 0 || pending !== '0) begin
            n_err++;
            $display("FAIL single_end: extra_rx=%0d missing=%0d pending=%0d, want 0/0/0",
                     rx_q.size(), exp_q.size(), pending);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] a;
        uart_en = 1'b1;
        fix_lat = 3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            repeat_press = 1'b1;
            repeat (100) @(negedge clk);
            n_vec++;
            if (rx_q.size() != 1) begin
                n_err++;
                $display("FAIL repeat_count[%0d]: got %0d frames bytes, want 1", k, rx_q.size());
            end
            if (rx_q.size() != 0) begin
                a = rx_q.pop_front();
                n_vec++;
                if (a !== 8'h5A) begin
                    n_err++;
                    $display("FAIL repeat_byte[%0d]: got %h want 5a", k, a);
                end
            end
            rx_q.delete();
            repeat_press = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        logic [7:0] e, a;
        uart_en = 1'b1;
        fix_lat = 2;
        @(negedge clk);
        code = 32'h12345678;
        new_code = 1'b1;
        repeat_press = 1'b1;
        push_exp(32'h12345678, 1'b0);
        @(negedge clk);
        new_code = 1'b0;
        wait_rx(exp_q.size(), 500, ok);
        repeat (40) @(negedge clk);
        n_vec++;
        if (!ok || rx_q.size() != exp_q.size() || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle: got %0d bytes ovf=%b, want %0d bytes ovf=0",
                     rx_q.size(), overflow, exp_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL same_cycle_byte: got %h want %h", a, e);
            end
        end
        rx_q.delete();
        exp_q.delete();
        repeat_press = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_fill();
        bit ok;
        logic [7:0] e, a;
        logic [31:0] c;
        do_reset();
        uart_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c = 32'hC0DE0000 + 32'(k * 32'h01010101);
            code = c;
            new_code = 1'b1;
            push_exp(c, 1'b0);
            @(negedge clk);
        end
        new_code = 1'b0;
        n_vec++;
        if (pending !== PW'(4) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill_pending: pending=%0d ovf=%b, want 4/0", pending, overflow);
        end
        n_vec++;
        if (tx_send !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL fill_stall: send=%b data=%h, want 1/a5", tx_send, tx_data);
        end
        fix_lat = 1;
        uart_en = 1'b1;
        wait_rx(exp_q.size(), 2000, ok);
        repeat (20) @(negedge clk);
        n_vec++;
        if (!ok || rx_q.size() != exp_q.size() || pending !== '0) begin
            n_err++;
            $display("FAIL fill_drain: got %0d bytes pending=%0d, want %0d/0",
                     rx_q.size(), pending, exp_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL fill_byte: got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_overflow();
        bit seen;
        do_reset();
        uart_en = 1'b0;
        code = 32'h0BADF00D;
        new_code = 1'b1;
        @(negedge clk);
        new_code = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx_send;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL ovf_send_timeout: send=%b want 1", tx_send);
        end
        for (int k = 0; k < 5; k++) begin
            code = 32'h00000100 + 32'(k);
            new_code = 1'b1;
            @(negedge clk);
            if (k == 3) begin
                n_vec++;
                if (overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_early: ovf=%b want 0", overflow);
                end
            end
        end
        new_code = 1'b0;
        n_vec++;
        if (pending !== PW'(4) || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_full: pending=%0d ovf=%b, want 4/1", pending, overflow);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        logic [7:0] e, a;
        do_reset();
        fix_lat = 2;
        uart_en = 1'b1;
        code = 32'hCAFEBABE;
        new_code = 1'b1;
        push_exp(32'hCAFEBABE, 1'b0);
        @(negedge clk);
        code = 32'h55AA55AA;
        @(negedge clk);
        new_code = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            seen = tx_send && (rx_q.size() == 2);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL midrst_timeout: rx=%0d want 2 with send high", rx_q.size());
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (tx_send !== 1'b0 || pending !== '0) begin
            n_err++;
            $display("FAIL midrst_async: send=%b pending=%0d, want 0/0", tx_send, pending);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 2 || tx_send !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_residual: rx=%0d send=%b, want 2/0", rx_q.size(), tx_send);
        end
        for (int i = 0; i < 2 && rx_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL midrst_byte: got %h want %h", a, e);
            end
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] e, a;
        logic [31:0] c;
        do_reset();
        uart_en  = 1'b1;
        rand_lat = 1'b1;
        for (int k = 0; k < 50; k++) begin
            for (int w = 0; w < 2000 && pending >= PW'(3); w++) @(negedge clk);
            c = $urandom();
            code = c;
            new_code = 1'b1;
            push_exp(c, 1'b0);
            @(negedge clk);
            new_code = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_rx(exp_q.size(), 40000, ok);
        repeat (30) @(negedge clk);
        n_vec++;
        if (!ok || rx_q.size() != exp_q.size() || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rand_count: got %0d bytes ovf=%b, want %0d/0",
                     rx_q.size(), overflow, exp_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL rand_byte: got %h want %h", a, e);
            end
        end
        rand_lat = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        code         = '0;
        new_code     = 1'b0;
        repeat_press = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_code();
        test_repeat();
        test_same_cycle();
        test_fill();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
